// File: rtl/fetch_pkg.sv
// fetch_pkg
//   Shared definitions for the instruction-fetch / prefetch slice.
//   - FETCH_XLEN        : default datapath width
//   - PC_INC            : sequential fetch stride in bytes
//   - DEFAULT_RESET_PC  : default PC loaded on reset
//   - fetch_entry_t     : one prefetch queue entry {pc, instr} at default width
package fetch_pkg;
  localparam int unsigned FETCH_XLEN = 32;
  localparam int unsigned PC_INC = 4;
  localparam logic [FETCH_XLEN-1:0] DEFAULT_RESET_PC = '0;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo
//   Synchronous circular FIFO holding prefetched entries.
//   Ports:
//     clk, reset   : clock, synchronous active-high reset
//     push, data   : enqueue request and entry (accepted when not full, or
//                    when full and a pop happens in the same cycle)
//     pop          : dequeue head (ignored when empty)
//     clear        : drop all entries; wins over push and pop
//     count        : current occupancy (0..DEPTH)
//     full, empty  : occupancy flags
//     head         : entry at the read pointer (don't-care when empty)
//   Handshake: an entry moves only on a rising edge where its side's
//   request is high and the queue can honour it; no combinational path
//   from push/pop to full/empty/head.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic [WIDTH-1:0]           head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !clear;
  // A full queue still takes a push when the head leaves in the same cycle.
  assign do_push = push && !clear && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit
//   Instruction-fetch stage: sequential PC generation, prefetch queue of
//   {pc, instr} pairs, valid/ready hand-off to decode, redirect flush.
//   Ports:
//     clk, reset          : clock, synchronous active-high reset
//     fetch_en            : fetch permitted this cycle
//     redirect            : branch/jump; flushes queue, reloads fetch_pc
//     redirect_addr       : target PC (bits [1:0] ignored)
//     imem_addr           : word address into the combinational ROM
//     imem_rdata          : instruction at imem_addr, same cycle
//     out_valid/out_ready : head hand-off; a transfer happens on a rising
//                           edge where both are high; out_valid is a pure
//                           function of queue state, never of out_ready
//     out_instr, out_pc   : head entry (don't-care while out_valid = 0)
//     if_flush            : equals redirect; downstream kills IF/ID
//   Optional feature, macro FETCH_STATS_EN:
//     stat_fetched        : saturating count of pushes
//     stat_flushed        : saturating count of entries dropped by redirect
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              IMEM_AW  = 6,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  input  logic               redirect,
  input  logic [XLEN-1:0]    redirect_addr,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [XLEN-1:0]    imem_rdata,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    out_instr,
  output logic [XLEN-1:0]    out_pc,
  output logic               if_flush
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]        stat_fetched,
  output logic [31:0]        stat_flushed
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   fifo_count;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;
  logic            push;
  entry_t          head;
  entry_t          tail;

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign push      = fetch_en && !redirect && (!fifo_full || pop);
  assign tail      = '{pc: fetch_pc, instr: imem_rdata};
  assign if_flush  = redirect;
  assign imem_addr = fetch_pc[IMEM_AW+1:2];
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .data  (tail),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

  // Reset beats redirect, redirect beats sequential advance.
  always_ff @(posedge clk) begin
    if (reset)         fetch_pc <= RESET_PC;
    else if (redirect) fetch_pc <= {redirect_addr[XLEN-1:2], 2'b00};
    else if (push)     fetch_pc <= fetch_pc + XLEN'(PC_INC);
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (fifo_full == (fifo_count == CW'(DEPTH)));
  end

`ifdef FETCH_STATS_EN
  logic [32:0] flushed_sum;
  assign flushed_sum = {1'b0, stat_flushed} + 33'(fifo_count);

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fetched <= '0;
      stat_flushed <= '0;
    end else begin
      if (push && stat_fetched != '1) stat_fetched <= stat_fetched + 32'd1;
      // Entries held at the redirect edge are the ones thrown away.
      if (redirect) stat_flushed <= flushed_sum[32] ? '1 : flushed_sum[31:0];
    end
  end
`endif
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit
//   Bench for fetch_prefetch_unit (XLEN=32, IMEM_AW=6, DEPTH=4, RESET_PC=0).
//   ROM word k holds value k. A negedge monitor keeps an expected queue of
//   {pc, instr} entries and checks every head that decode accepts; scenario
//   tasks check reset state, backpressure, redirect, fetch_en and reset
//   override. Build with FETCH_STATS_EN defined to also cover the counters.
module tb_fetch_prefetch_unit;
  localparam int XLEN = 32;
  localparam int IMEM_AW = 6;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               fetch_en = 1'b0;
  logic               redirect = 1'b0;
  logic [XLEN-1:0]    redirect_addr = '0;
  logic [IMEM_AW-1:0] imem_addr;
  logic [XLEN-1:0]    imem_rdata;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [XLEN-1:0]    out_instr;
  logic [XLEN-1:0]    out_pc;
  logic               if_flush;
`ifdef FETCH_STATS_EN
  logic [31:0]        stat_fetched;
  logic [31:0]        stat_flushed;
`endif

  int checks = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  logic [31:0] model_pc = RESET_PC;

  always #5 clk = ~clk;

  // ROM: word k = k
  assign imem_rdata = XLEN'(imem_addr);

  fetch_prefetch_unit #(
    .XLEN(XLEN), .IMEM_AW(IMEM_AW), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_en      (fetch_en),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .if_flush      (if_flush)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched  (stat_fetched),
    .stat_flushed  (stat_flushed)
`endif
  );

  // Scoreboard monitor: inputs are stable at the negedge, so it compares
  // the head against the model, then advances the model across the next edge.
  always @(negedge clk) begin
    logic [63:0] e;
    logic        pop_m;
    int          sz;
    sz = exp_q.size();
    checks++;
    if (out_valid !== (sz != 0)) begin
      failures++;
      $display("FAIL mon_valid got=%0b exp=%0b t=%0t", out_valid, sz != 0, $time);
    end
    checks++;
    if (if_flush !== redirect) begin
      failures++;
      $display("FAIL mon_if_flush got=%0b exp=%0b t=%0t", if_flush, redirect, $time);
    end
    checks++;
    if (imem_addr !== model_pc[7:2]) begin
      failures++;
      $display("FAIL mon_imem_addr got=%0h exp=%0h t=%0t", imem_addr, model_pc[7:2], $time);
    end
    pop_m = (sz != 0) && out_ready;
    if (pop_m) begin
      e = exp_q.pop_front();
      checks++;
      if ({out_pc, out_instr} !== e) begin
        failures++;
        $display("FAIL mon_head got pc=%0h instr=%0h exp pc=%0h instr=%0h t=%0t",
                 out_pc, out_instr, e[63:32], e[31:0], $time);
      end
    end
    if (reset) begin
      exp_q.delete();
      model_pc = RESET_PC;
    end else if (redirect) begin
      exp_q.delete();
      model_pc = {redirect_addr[31:2], 2'b00};
    end else if (fetch_en && (sz < DEPTH || pop_m)) begin
      exp_q.push_back({model_pc, 26'd0, model_pc[7:2]});
      model_pc = model_pc + 32'd4;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect = 1'b0;
    fetch_en = 1'b0;
    out_ready = 1'b0;
    redirect_addr = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++;
    if (if_flush !== 1'b0) begin failures++; $display("FAIL reset_if_flush got=%0b exp=0", if_flush); end
    checks++;
    if (imem_addr !== RESET_PC[7:2]) begin failures++; $display("FAIL reset_imem_addr got=%0h exp=%0h", imem_addr, RESET_PC[7:2]); end
    checks++;
    if (dut.fetch_pc !== RESET_PC) begin failures++; $display("FAIL reset_fetch_pc got=%0h exp=%0h", dut.fetch_pc, RESET_PC); end
    checks++;
    if (dut.fifo_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", dut.fifo_count); end
`ifdef FETCH_STATS_EN
    checks++;
    if (stat_fetched !== 32'd0 || stat_flushed !== 32'd0) begin
      failures++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", stat_fetched, stat_flushed);
    end
`endif
  endtask

  task automatic test_stream();
    do_reset();
    fetch_en = 1'b1;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      failures++; $display("FAIL stream_first got valid=%0b pc=%0h exp valid=1 pc=0", out_valid, out_pc);
    end
    for (int i = 0; i < 63; i++) begin
      step();
      checks++;
      if (dut.fifo_count !== 3'd1) begin failures++; $display("FAIL stream_occupancy got=%0d exp=1", dut.fifo_count); end
    end
    checks++;
    if (dut.fetch_pc !== 32'h100 || imem_addr !== 6'd0) begin
      failures++; $display("FAIL stream_wrap got pc=%0h addr=%0h exp pc=100 addr=0", dut.fetch_pc, imem_addr);
    end
    checks++;
    if (out_pc !== 32'hFC || out_instr !== 32'd63) begin
      failures++; $display("FAIL stream_last got pc=%0h instr=%0h exp pc=fc instr=3f", out_pc, out_instr);
    end
    step();
    checks++;
    if (out_pc !== 32'h100 || out_instr !== 32'd0) begin
      failures++; $display("FAIL stream_wrapped_head got pc=%0h instr=%0h exp pc=100 instr=0", out_pc, out_instr);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    fetch_en = 1'b1;
    out_ready = 1'b0;
    repeat (10) step();
    checks++;
    if (dut.fifo_count !== 3'd4) begin failures++; $display("FAIL bp_count got=%0d exp=4", dut.fifo_count); end
    checks++;
    if (dut.fetch_pc !== 32'h10) begin failures++; $display("FAIL bp_fetch_pc got=%0h exp=10", dut.fetch_pc); end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_instr !== 32'(i)) begin
        failures++; $display("FAIL bp_head%0d got pc=%0h instr=%0h exp pc=%0h instr=%0h", i, out_pc, out_instr, i * 4, i);
      end
      checks++;
      if (dut.fifo_count !== 3'd4) begin failures++; $display("FAIL bp_full_pushpop%0d got=%0d exp=4", i, dut.fifo_count); end
      step();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    fetch_en = 1'b1;
    out_ready = 1'b1;
    repeat (6) step();
    out_ready = 1'b0;
    repeat (2) step();
    checks++;
    if (dut.fifo_count !== 3'd3 || out_pc !== 32'h14) begin
      failures++; $display("FAIL redir_pre got count=%0d pc=%0h exp count=3 pc=14", dut.fifo_count, out_pc);
    end
    redirect = 1'b1;
    redirect_addr = 32'h23;
    #1;
    checks++;
    if (if_flush !== 1'b1) begin failures++; $display("FAIL redir_if_flush got=%0b exp=1", if_flush); end
    @(posedge clk);
    #1;
    redirect = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL redir_valid_after got=%0b exp=0", out_valid); end
    checks++;
    if (dut.fetch_pc !== 32'h20) begin failures++; $display("FAIL redir_fetch_pc got=%0h exp=20", dut.fetch_pc); end
`ifdef FETCH_STATS_EN
    checks++;
    if (stat_fetched !== 32'd8) begin failures++; $display("FAIL stat_fetched got=%0d exp=8", stat_fetched); end
    checks++;
    if (stat_flushed !== 32'd3) begin failures++; $display("FAIL stat_flushed got=%0d exp=3", stat_flushed); end
`endif
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_instr !== 32'd8) begin
      failures++; $display("FAIL redir_target got valid=%0b pc=%0h instr=%0h exp valid=1 pc=20 instr=8", out_valid, out_pc, out_instr);
    end
  endtask

  task automatic test_fetch_disable();
    do_reset();
    fetch_en = 1'b1;
    out_ready = 1'b1;
    repeat (4) step();
    fetch_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (dut.fetch_pc !== 32'h10) begin failures++; $display("FAIL dis_fetch_pc%0d got=%0h exp=10", i, dut.fetch_pc); end
    end
    checks++;
    if (out_valid !== 1'b0 || dut.fifo_count !== 3'd0) begin
      failures++; $display("FAIL dis_drained got valid=%0b count=%0d exp valid=0 count=0", out_valid, dut.fifo_count);
    end
    fetch_en = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h10) begin
      failures++; $display("FAIL dis_resume got valid=%0b pc=%0h exp valid=1 pc=10", out_valid, out_pc);
    end
  endtask

  task automatic test_reset_override();
    do_reset();
    fetch_en = 1'b1;
    out_ready = 1'b0;
    repeat (6) step();
    reset = 1'b1;
    redirect = 1'b1;
    redirect_addr = 32'h40;
    step();
    reset = 1'b0;
    redirect = 1'b0;
    fetch_en = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_ovr_valid got=%0b exp=0", out_valid); end
    checks++;
    if (dut.fetch_pc !== RESET_PC) begin failures++; $display("FAIL rst_ovr_fetch_pc got=%0h exp=%0h", dut.fetch_pc, RESET_PC); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 200; i++) begin
      fetch_en = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      redirect = ($urandom_range(0, 15) == 0);
      redirect_addr = 32'($urandom_range(0, 255));
      step();
    end
    redirect = 1'b0;
    fetch_en = 1'b0;
    out_ready = 1'b1;
    repeat (6) step();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_fetch_disable();
    test_reset_override();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
